// File: rtl/sobel_stream_avst.sv
`default_nettype none
// ============================================================================
// Module      : sobel_stream_avst
// Description : Streaming 3x3 Sobel edge detector with Avalon-ST sink/source.
//               Two line buffers plus a sliding 3x3 window; after the last
//               input pixel the frame is drained by injecting zero pixels.
// Revision    : 1.0 - initial release
// ============================================================================
module sobel_stream_avst #(
    parameter int          IMG_X_SIZE = 320,
    parameter int          IMG_Y_SIZE = 240,
    parameter int          DATA_W     = 8,
    parameter int          MODE       = 0,
    parameter int unsigned THRESHOLD  = 128
) (
    input  logic              csi_clkrst_clk,
    input  logic              csi_clkrst_reset,
    input  logic [DATA_W-1:0] asi_sink1_data,
    input  logic              asi_sink1_startofpacket,
    input  logic              asi_sink1_endofpacket,
    input  logic              asi_sink1_valid,
    output logic              asi_sink1_ready,
    output logic [DATA_W-1:0] aso_source1_data,
    output logic              aso_source1_startofpacket,
    output logic              aso_source1_endofpacket,
    output logic              aso_source1_valid,
    input  logic              aso_source1_ready,
    output logic              frame_err_o
);

    localparam int c_npix  = IMG_X_SIZE * IMG_Y_SIZE;
    // Real pixels plus the zero pixels needed to push the last window out.
    localparam int c_nadv  = c_npix + IMG_X_SIZE + 1;
    localparam int c_cnt_w = $clog2(c_nadv + 1);
    localparam int c_col_w = $clog2(IMG_X_SIZE);
    localparam int c_row_w = $clog2(IMG_Y_SIZE);
    localparam int c_gw    = DATA_W + 3;
    localparam int c_mw    = DATA_W + 4;
    localparam logic [c_mw-1:0] c_sat = c_mw'((1 << DATA_W) - 1);
    localparam logic [c_mw-1:0] c_thr = c_mw'(THRESHOLD);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_col_w-1:0]   r_col;
    logic [c_col_w-1:0]   r_ox;
    logic [c_row_w-1:0]   r_oy;
    logic                 r_err;
    logic                 r_out_valid;
    logic                 r_out_sop;
    logic                 r_out_eop;
    logic [DATA_W-1:0]    r_out_data;

    logic [DATA_W-1:0]    r_lb0 [IMG_X_SIZE];
    logic [DATA_W-1:0]    r_lb1 [IMG_X_SIZE];
    logic [DATA_W-1:0]    r_win [3][3];
    logic [DATA_W-1:0]    w_nwin [3][3];

    logic                 w_out_free;
    logic                 w_sink_ready;
    logic                 w_accept;
    logic                 w_start;
    logic                 w_run_acc;
    logic                 w_inject;
    logic                 w_adv;
    logic                 w_emit;
    logic                 w_last_in;
    logic                 w_flush_done;
    logic                 w_border;
    logic [DATA_W-1:0]    w_pix;
    logic [c_cnt_w-1:0]   w_idx;
    logic [c_col_w-1:0]   w_col;
    logic signed [c_gw-1:0] w_gx;
    logic signed [c_gw-1:0] w_gy;
    logic signed [c_gw-1:0] w_ax;
    logic signed [c_gw-1:0] w_ay;
    logic [c_mw-1:0]      w_mag;
    logic [DATA_W-1:0]    w_res;

    function automatic logic signed [c_gw-1:0] f_ext(input logic [DATA_W-1:0] p);
        f_ext = $signed({3'b000, p});
    endfunction

    // Handshake and pipeline-advance qualifiers.
    assign w_out_free   = !r_out_valid || aso_source1_ready;
    assign w_sink_ready = (r_state != ST_FLUSH) && w_out_free;
    assign w_accept     = asi_sink1_valid && w_sink_ready;
    assign w_start      = w_accept && (r_state == ST_IDLE) && asi_sink1_startofpacket;
    assign w_run_acc    = w_accept && (r_state == ST_RUN);
    assign w_flush_done = (r_cnt == c_cnt_w'(c_nadv));
    assign w_inject     = (r_state == ST_FLUSH) && w_out_free && !w_flush_done;
    assign w_adv        = w_start || w_run_acc || w_inject;
    assign w_pix        = w_inject ? '0 : asi_sink1_data;
    assign w_idx        = w_start ? '0 : r_cnt;
    assign w_col        = w_start ? '0 : r_col;
    assign w_last_in    = (w_idx == c_cnt_w'(c_npix - 1));
    assign w_emit       = w_adv && (w_idx >= c_cnt_w'(IMG_X_SIZE + 1));
    assign w_border     = (r_ox == '0) || (r_ox == c_col_w'(IMG_X_SIZE - 1)) ||
                          (r_oy == '0) || (r_oy == c_row_w'(IMG_Y_SIZE - 1));

    // Window after the shift: new column = two buffered rows plus the new pixel.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            w_nwin[r][0] = r_win[r][1];
            w_nwin[r][1] = r_win[r][2];
        end
        w_nwin[0][2] = r_lb1[w_col];
        w_nwin[1][2] = r_lb0[w_col];
        w_nwin[2][2] = w_pix;
    end

    // Sobel gradients and magnitude of the shifted window.
    always_comb begin
        w_gx  = (f_ext(w_nwin[0][2]) + (f_ext(w_nwin[1][2]) <<< 1) + f_ext(w_nwin[2][2])) -
                (f_ext(w_nwin[0][0]) + (f_ext(w_nwin[1][0]) <<< 1) + f_ext(w_nwin[2][0]));
        w_gy  = (f_ext(w_nwin[2][0]) + (f_ext(w_nwin[2][1]) <<< 1) + f_ext(w_nwin[2][2])) -
                (f_ext(w_nwin[0][0]) + (f_ext(w_nwin[0][1]) <<< 1) + f_ext(w_nwin[0][2]));
        w_ax  = w_gx[c_gw-1] ? -w_gx : w_gx;
        w_ay  = w_gy[c_gw-1] ? -w_gy : w_gy;
        w_mag = {1'b0, $unsigned(w_ax)} + {1'b0, $unsigned(w_ay)};
        w_res = '0;
        if (MODE == 1) begin
            w_res = (w_mag >= c_thr) ? '1 : '0;
        end else begin
            w_res = (w_mag > c_sat) ? '1 : w_mag[DATA_W-1:0];
        end
    end

    // FSM state register.
    always_ff @(posedge csi_clkrst_clk or posedge csi_clkrst_reset) begin
        if (csi_clkrst_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: FLUSH ends when the final EOP beat leaves the source.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_start) w_state_nxt = ST_RUN;
            ST_RUN:   if (w_run_acc && w_last_in) w_state_nxt = ST_FLUSH;
            ST_FLUSH: if (w_flush_done && r_out_valid && aso_source1_ready) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Position counters and the sticky framing-error flag.
    always_ff @(posedge csi_clkrst_clk or posedge csi_clkrst_reset) begin
        if (csi_clkrst_reset) begin
            r_cnt <= '0;
            r_col <= '0;
            r_ox  <= '0;
            r_oy  <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_adv) begin
                r_cnt <= w_idx + c_cnt_w'(1);
                r_col <= (w_col == c_col_w'(IMG_X_SIZE - 1)) ? '0 : w_col + c_col_w'(1);
            end
            if (w_start) begin
                r_ox <= '0;
                r_oy <= '0;
            end else if (w_emit) begin
                if (r_ox == c_col_w'(IMG_X_SIZE - 1)) begin
                    r_ox <= '0;
                    r_oy <= r_oy + c_row_w'(1);
                end else begin
                    r_ox <= r_ox + c_col_w'(1);
                end
            end
            if (w_start) begin
                // A one-beat packet is too short to be a frame.
                r_err <= asi_sink1_endofpacket;
            end else if (w_run_acc && (asi_sink1_startofpacket ||
                                       (asi_sink1_endofpacket && !w_last_in))) begin
                r_err <= 1'b1;
            end
        end
    end

    // Line buffers and window register; contents need no reset.
    always_ff @(posedge csi_clkrst_clk) begin
        if (w_adv) begin
            r_lb0[w_col] <= w_pix;
            r_lb1[w_col] <= r_lb0[w_col];
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    r_win[r][c] <= w_nwin[r][c];
                end
            end
        end
    end

    // Output register: loads a result on emit, otherwise drains when accepted.
    always_ff @(posedge csi_clkrst_clk or posedge csi_clkrst_reset) begin
        if (csi_clkrst_reset) begin
            r_out_valid <= 1'b0;
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
            r_out_data  <= '0;
        end else if (w_emit) begin
            r_out_valid <= 1'b1;
            r_out_sop   <= (r_ox == '0) && (r_oy == '0);
            r_out_eop   <= (r_ox == c_col_w'(IMG_X_SIZE - 1)) && (r_oy == c_row_w'(IMG_Y_SIZE - 1));
            r_out_data  <= w_border ? '0 : w_res;
        end else if (aso_source1_ready) begin
            r_out_valid <= 1'b0;
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
        end
    end

    assign asi_sink1_ready           = w_sink_ready;
    assign aso_source1_data          = r_out_data;
    assign aso_source1_startofpacket = r_out_sop;
    assign aso_source1_endofpacket   = r_out_eop;
    assign aso_source1_valid         = r_out_valid;
    assign frame_err_o               = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sobel_stream_avst.sv
`default_nettype none
// ============================================================================
// Module      : tb_sobel_stream_avst
// Description : Scoreboard bench for sobel_stream_avst on a 4x4 frame. Three
//               instances (saturated, threshold 80, threshold 100) share the
//               same stimulus and output backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sobel_stream_avst;

    localparam int X = 4;
    localparam int Y = 4;
    localparam int N = X * Y;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] sink_data = '0;
    logic       sink_sop = 1'b0;
    logic       sink_eop = 1'b0;
    logic       sink_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic       sink_ready0, sink_ready1, sink_ready2;
    logic [7:0] d0, d1, d2;
    logic       s0, s1, s2, e0, e1, e2, v0, v1, v2, err0, err1, err2;

    always #5 clk = ~clk;

    sobel_stream_avst #(.IMG_X_SIZE(X), .IMG_Y_SIZE(Y), .DATA_W(8), .MODE(0), .THRESHOLD(128)) u_m0 (
        .csi_clkrst_clk(clk), .csi_clkrst_reset(rst),
        .asi_sink1_data(sink_data), .asi_sink1_startofpacket(sink_sop),
        .asi_sink1_endofpacket(sink_eop), .asi_sink1_valid(sink_valid), .asi_sink1_ready(sink_ready0),
        .aso_source1_data(d0), .aso_source1_startofpacket(s0), .aso_source1_endofpacket(e0),
        .aso_source1_valid(v0), .aso_source1_ready(out_ready), .frame_err_o(err0));

    sobel_stream_avst #(.IMG_X_SIZE(X), .IMG_Y_SIZE(Y), .DATA_W(8), .MODE(1), .THRESHOLD(80)) u_t80 (
        .csi_clkrst_clk(clk), .csi_clkrst_reset(rst),
        .asi_sink1_data(sink_data), .asi_sink1_startofpacket(sink_sop),
        .asi_sink1_endofpacket(sink_eop), .asi_sink1_valid(sink_valid), .asi_sink1_ready(sink_ready1),
        .aso_source1_data(d1), .aso_source1_startofpacket(s1), .aso_source1_endofpacket(e1),
        .aso_source1_valid(v1), .aso_source1_ready(out_ready), .frame_err_o(err1));

    sobel_stream_avst #(.IMG_X_SIZE(X), .IMG_Y_SIZE(Y), .DATA_W(8), .MODE(1), .THRESHOLD(100)) u_t100 (
        .csi_clkrst_clk(clk), .csi_clkrst_reset(rst),
        .asi_sink1_data(sink_data), .asi_sink1_startofpacket(sink_sop),
        .asi_sink1_endofpacket(sink_eop), .asi_sink1_valid(sink_valid), .asi_sink1_ready(sink_ready2),
        .aso_source1_data(d2), .aso_source1_startofpacket(s2), .aso_source1_endofpacket(e2),
        .aso_source1_valid(v2), .aso_source1_ready(out_ready), .frame_err_o(err2));

    typedef struct {
        int m0;
        int t80;
        int t100;
        int sop;
        int eop;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   img[N];
    int   bp_mode = 0;
    bit   stall_done = 1'b0;
    int   frame_out_idx = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: condition not met (t=%0t)", name, $time);
    endtask

    function automatic int pix(input int x, input int y);
        return img[y * X + x];
    endfunction

    // Reference: Sobel of a whole in-memory frame, borders forced to zero.
    function automatic exp_t ref_exp(input int x, input int y);
        exp_t r;
        int gx, gy, mag;
        r.sop = (x == 0 && y == 0) ? 1 : 0;
        r.eop = (x == X - 1 && y == Y - 1) ? 1 : 0;
        r.m0 = 0; r.t80 = 0; r.t100 = 0;
        if (x > 0 && x < X - 1 && y > 0 && y < Y - 1) begin
            gx = (pix(x+1, y-1) + 2*pix(x+1, y) + pix(x+1, y+1))
               - (pix(x-1, y-1) + 2*pix(x-1, y) + pix(x-1, y+1));
            gy = (pix(x-1, y+1) + 2*pix(x, y+1) + pix(x+1, y+1))
               - (pix(x-1, y-1) + 2*pix(x, y-1) + pix(x+1, y-1));
            mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
            r.m0   = (mag > 255) ? 255 : mag;
            r.t80  = (mag >= 80) ? 255 : 0;
            r.t100 = (mag >= 100) ? 255 : 0;
        end
        return r;
    endfunction

    function automatic void fill_img(input int kind);
        for (int i = 0; i < N; i++) begin
            case (kind)
                0:       img[i] = 77;
                1:       img[i] = ((i % X) < 2) ? 0 : 100;
                2:       img[i] = 10 * (i % X);
                4:       img[i] = int'($urandom_range(0, 40));
                default: img[i] = int'($urandom_range(0, 255));
            endcase
        end
    endfunction

    // Drive one sink beat and hold it until the DUT accepts it (bounded).
    task automatic send_beat(input int d, input bit s, input bit e);
        int waited = 0;
        bit ok = 1'b0;
        sink_data  = 8'(d);
        sink_sop   = s;
        sink_eop   = e;
        sink_valid = 1'b1;
        while (!ok && waited < 500) begin
            @(negedge clk);
            if (sink_ready0) ok = 1'b1;
            else waited++;
        end
        if (!ok) fail("sink_accept_timeout");
        @(posedge clk);
        #1;
        sink_valid = 1'b0;
        sink_sop   = 1'b0;
        sink_eop   = 1'b0;
    endtask

    task automatic send_frame(input int kind, input int eop_beat, input int stop_after,
                              input bit chk_lat, input bit gaps);
        int nb, nexp;
        fill_img(kind);
        nb   = (stop_after > 0) ? stop_after : N;
        nexp = (stop_after > 0) ? stop_after - (X + 1) : N;
        for (int k = 0; k < nexp; k++) sb.push_back(ref_exp(k % X, k / X));
        for (int i = 0; i < nb; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            send_beat(img[i], i == 0, (i == N - 1) || (i == eop_beat));
            if (i == 0) check("err_clear_on_sop", int'(err0), 0);
            if (chk_lat && i == X) check("valid_before_beat5", int'(v0), 0);
            if (chk_lat && i == X + 1) check("valid_after_beat5", int'(v0), 1);
            if (eop_beat >= 0 && i == eop_beat - 1) check("err_before_bad_eop", int'(err0), 0);
            if (eop_beat >= 0 && i == eop_beat) check("err_after_bad_eop", int'(err0), 1);
            if (eop_beat >= 0 && i == N - 1) check("err_sticky", int'(err0), 1);
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (sb.size() != 0) fail("drain_timeout");
    endtask

    // Output backpressure: always ready, random, or one 5-cycle stall at output 6.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode == 1) begin
                out_ready = ($urandom_range(0, 3) != 0);
            end else if (bp_mode == 2 && !stall_done && v0 && frame_out_idx == 6) begin
                out_ready = 1'b0;
                repeat (5) begin
                    @(posedge clk);
                    #1;
                end
                out_ready  = 1'b1;
                stall_done = 1'b1;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard on every source handshake.
    initial begin
        bit   hold;
        int   hd, hs, he;
        exp_t ex;
        hold = 1'b0; hd = 0; hs = 0; he = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 1'b0;
            end else begin
                if (v0 && hold) begin
                    check("stall_data", int'(d0), hd);
                    check("stall_sop", int'(s0), hs);
                    check("stall_eop", int'(e0), he);
                end
                if (v0 && !out_ready) begin
                    check("stall_sink_ready", int'(sink_ready0), 0);
                    if (!hold) begin
                        hold = 1'b1; hd = int'(d0); hs = int'(s0); he = int'(e0);
                    end
                end
                if (v0 && out_ready) begin
                    hold = 1'b0;
                    if (sb.size() == 0) begin
                        fail("extra_output");
                    end else begin
                        ex = sb.pop_front();
                        check("data_mode0", int'(d0), ex.m0);
                        check("data_thr80", int'(d1), ex.t80);
                        check("data_thr100", int'(d2), ex.t100);
                        check("sop", int'(s0), ex.sop);
                        check("eop", int'(e0), ex.eop);
                        check("valid_thr80", int'(v1), 1);
                        check("valid_thr100", int'(v2), 1);
                        frame_out_idx = (ex.sop != 0) ? 1 : frame_out_idx + 1;
                    end
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", int'(v0), 0);
        check("reset_data", int'(d0), 0);
        check("reset_sop_eop", int'(s0) + int'(e0), 0);
        check("reset_err", int'(err0), 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", int'(sink_ready0), 1);
        @(posedge clk);
        #1;

        // Beats without SOP in IDLE are dropped.
        for (int i = 0; i < 3; i++) send_beat(int'($urandom_range(0, 255)), 1'b0, 1'b0);

        send_frame(0, -1, -1, 1'b1, 1'b0);   // constant 77, latency check
        send_frame(1, -1, -1, 1'b0, 1'b0);   // vertical step
        send_frame(2, -1, -1, 1'b0, 1'b0);   // ramp 10*x
        wait_drain(500);

        bp_mode = 2;
        stall_done = 1'b0;
        send_frame(3, -1, -1, 1'b0, 1'b0);
        wait_drain(500);
        check("stall_seen", int'(stall_done), 1);
        bp_mode = 0;

        send_frame(3, 8, -1, 1'b0, 1'b0);    // early EOP on beat 9
        send_frame(3, -1, -1, 1'b0, 1'b0);   // SOP clears the flag
        wait_drain(500);

        // Reset after 7 accepted beats; only the two outputs already produced count.
        send_frame(3, -1, 7, 1'b0, 1'b0);
        wait_drain(500);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midreset_valid", int'(v0), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midreset_ready", int'(sink_ready0), 1);
        repeat (10) @(posedge clk);
        #1;
        send_frame(3, -1, -1, 1'b0, 1'b0);
        wait_drain(500);

        bp_mode = 1;
        for (int f = 0; f < 4; f++) send_frame((f % 2 == 0) ? 3 : 4, -1, -1, 1'b0, 1'b1);
        wait_drain(3000);
        bp_mode = 0;
        repeat (20) @(posedge clk);
        #1;
        check("final_valid", int'(v0), 0);
        check("final_err", int'(err0), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sobel_stream_avst.md
SOBEL_STREAM_AVST -- requirements
Module: sobel_stream_avst

Interface
REQ-001 The block SHALL have parameter IMG_X_SIZE, default 320, meaning pixels per line (minimum 3).
REQ-002 The block SHALL have parameter IMG_Y_SIZE, default 240, meaning lines per frame (minimum 3).
REQ-003 The block SHALL have parameter DATA_W, default 8, meaning pixel width in bits for both input and output.
REQ-004 The block SHALL have parameter MODE, default 0, meaning 0 = saturated magnitude output and 1 = binary edge-map output.
REQ-005 The block SHALL have parameter THRESHOLD, default 128, meaning the binary cut-off, DATA_W+3 bits, unsigned.
REQ-006 The block SHALL have port csi_clkrst_clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-007 The block SHALL have port csi_clkrst_reset, input, 1 bit, an asynchronous active-high reset.
REQ-008 The block SHALL have ports asi_sink1_data (in, DATA_W), asi_sink1_startofpacket (in, 1), asi_sink1_endofpacket (in, 1), asi_sink1_valid (in, 1) and asi_sink1_ready (out, 1), forming the Avalon-ST sink with readyLatency 0.
REQ-009 The block SHALL have ports aso_source1_data (out, DATA_W), aso_source1_startofpacket (out, 1), aso_source1_endofpacket (out, 1), aso_source1_valid (out, 1) and aso_source1_ready (in, 1), forming the Avalon-ST source with readyLatency 0.
REQ-010 The block SHALL have port frame_err_o, output, 1 bit, a sticky flag for an input frame-length mismatch.

Function
REQ-011 The block SHALL implement a three-state FSM: IDLE, RUN and FLUSH.
REQ-012 In IDLE, asi_sink1_ready SHALL be 1; beats without SOP are accepted and discarded; an accepted SOP beat is pixel 0 and moves the FSM to RUN.
REQ-013 A sink beat SHALL be accepted when valid && ready, and ready SHALL equal (state != FLUSH) && (!aso_source1_valid || aso_source1_ready).
REQ-014 The block SHALL hold two line buffers of IMG_X_SIZE x DATA_W, plus a 3x3 window register; it SHALL NOT store a full frame.
REQ-015 An input pixel counter SHALL run from 0 to IMG_X_SIZE*IMG_Y_SIZE-1; acceptance of the last pixel SHALL move the FSM to FLUSH regardless of the sink EOP.
REQ-016 In FLUSH, the block SHALL inject IMG_X_SIZE+1 internal zero pixels, one per cycle in which the output register is free or being drained, then return to IDLE.
REQ-017 Output pixel k SHALL be the window centred on input pixel k; it SHALL become valid in the cycle after the acceptance (or injection) of pixel k+IMG_X_SIZE+1.
REQ-018 Gx SHALL be computed as (p[-1,+1]+2p[0,+1]+p[+1,+1])-(p[-1,-1]+2p[0,-1]+p[+1,-1]), and Gy as the transposed form, signed, DATA_W+3 bits.
REQ-019 The magnitude SHALL be |Gx|+|Gy|, unsigned, DATA_W+4 bits.
REQ-020 In MODE 0, the output SHALL be min(mag, 2^DATA_W-1).
REQ-021 In MODE 1, the output SHALL be all-ones if mag >= THRESHOLD, else 0.
REQ-022 Border outputs (x=0, x=IMG_X_SIZE-1, y=0, y=IMG_Y_SIZE-1) SHALL be 0 in both modes.
REQ-023 aso_source1_startofpacket SHALL be 1 only with output pixel 0, and aso_source1_endofpacket SHALL be 1 only with output pixel IMG_X_SIZE*IMG_Y_SIZE-1.
REQ-024 While aso_source1_valid=1 and aso_source1_ready=0, the output data, SOP, EOP and valid SHALL remain stable, and no input SHALL be accepted.
REQ-025 frame_err_o SHALL be set when an accepted sink EOP does not coincide with the last pixel, or when an SOP is accepted in RUN (the SOP beat is then treated as a normal pixel).
REQ-026 frame_err_o SHALL be cleared on acceptance of an SOP in IDLE.
REQ-027 When the FSM is in FLUSH and the last output has been delivered, the block SHALL enter IDLE the same cycle the final EOP beat is accepted downstream.

Reset
REQ-028 Reset assertion SHALL immediately force the FSM to IDLE, clear all counters, set aso_source1_valid, startofpacket, endofpacket and frame_err_o to 0, and set aso_source1_data to 0.
REQ-029 Line-buffer contents SHALL NOT require reset.
REQ-030 Reset asserted mid-frame SHALL abandon the frame, so that no partial output follows deassertion.
REQ-031 After reset deassertion, asi_sink1_ready SHALL be 1 in the first clock cycle.

Verification (IMG_X_SIZE=4, IMG_Y_SIZE=4, DATA_W=8)
REQ-032 Bench scenario, constant frame: all pixels 77, ready held at 1 -> 16 outputs, all 0; SOP on output 0, EOP on output 15; first valid output the cycle after accepting input beat 5.
REQ-033 Bench scenario, vertical step in MODE 0: columns 0-1 = 0, columns 2-3 = 100 -> outputs at (1,1), (2,1), (1,2) and (2,2) are 255 (|Gx|=400, saturated); all other outputs are 0.
REQ-034 Bench scenario, ramp in MODE 1: p=10*x; with THRESHOLD=100 all 16 outputs are 0; with THRESHOLD=80 the four interior outputs are 255.
REQ-035 Bench scenario, backpressure: aso_source1_ready is held at 0 for 5 cycles at output 6 -> output 6 stays stable, asi_sink1_ready=0 throughout, and the sequence matches the unstalled run bit-exactly.
REQ-036 Bench scenario, framing error: sink EOP is asserted on beat 9 -> frame_err_o=1 from the next cycle, 16 outputs are still produced, and the next valid SOP clears frame_err_o.
REQ-037 Bench scenario, reset mid-frame: reset is pulsed after 7 accepted beats and a clean frame is then sent -> exactly 16 outputs matching the reference model, with no stale data.
